// File: rtl/line_bank_if.sv
// Shared line type and the write channel from the vertex/projection engine into line_bank.
// The package lives here so it compiles ahead of both the interface and the bank.
package types;
  localparam int LINE_BITS = 10;

  typedef struct packed {
    logic [LINE_BITS-1:0] x0;
    logic [LINE_BITS-1:0] y0;
    logic [LINE_BITS-1:0] x1;
    logic [LINE_BITS-1:0] y1;
  } line_t;
endpackage

// Handshake: a write transfers on a rising clk_i edge where wr_valid_i && wr_ready_o.
// The master holds wr_index_i/wr_line_i/wr_last_i stable while wr_valid_i is high and
// wr_ready_o is low; wr_ready_o depends only on bank state, never on wr_valid_i.
interface line_bank_if #(
  parameter int NUM_LINES = 12
) ();
  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  logic             wr_valid_i;
  logic             wr_ready_o;
  logic [IDX_W-1:0] wr_index_i;
  types::line_t     wr_line_i;
  logic             wr_last_i;

  modport master (
    output wr_valid_i,
    output wr_index_i,
    output wr_line_i,
    output wr_last_i,
    input  wr_ready_o
  );

  modport slave (
    input  wr_valid_i,
    input  wr_index_i,
    input  wr_line_i,
    input  wr_last_i,
    output wr_ready_o
  );
endinterface

// File: rtl/line_bank.sv
// Double-buffered wireframe line store: writes fill a back bank, and the front bank seen by
// edge_function is replaced atomically at vblank once a complete frame has been committed.
module line_bank #(
  parameter int NUM_LINES = 12
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  line_bank_if.slave                       wr,
  input  logic                             frame_start_i,
  output types::line_t [NUM_LINES-1:0]     lines_o,
  output logic                             lines_valid_o,
  output logic                             swap_o,
  output logic                             wr_err_o,
  output logic [1:0]                       state_o
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } state_t;

  state_t                         state_q;
  state_t                         state_d;
  types::line_t [NUM_LINES-1:0]   back_q;
  types::line_t [NUM_LINES-1:0]   front_q;
  logic                           lines_valid_q;
  logic                           wr_err_q;

  logic                           ready;
  logic                           swap;
  logic                           commit;
  logic                           accept;
  logic                           in_range;

  assign accept   = wr.wr_valid_i && ready;
  assign in_range = 32'(wr.wr_index_i) < NUM_LINES;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // A frame_start arriving with the last write is deliberately not a commit: the swap waits
  // for the next vblank so the front bank never depends on same-cycle write data.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    swap    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      FILL: begin
        ready = 1'b1;
        if (wr.wr_valid_i && wr.wr_last_i) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_start_i) begin
          commit  = 1'b1;
          state_d = SWAP;
        end
      end
      SWAP: begin
        swap    = 1'b1;
        state_d = FILL;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Out-of-range slots still complete the handshake so the engine never stalls on bad data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      back_q   <= '0;
      wr_err_q <= 1'b0;
    end else if (accept) begin
      if (in_range) begin
        back_q[wr.wr_index_i] <= wr.wr_line_i;
      end else begin
        wr_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      front_q       <= '0;
      lines_valid_q <= 1'b0;
    end else if (commit) begin
      front_q       <= back_q;
      lines_valid_q <= 1'b1;
    end
  end

  assign wr.wr_ready_o = ready;
  assign lines_o       = front_q;
  assign lines_valid_o = lines_valid_q;
  assign swap_o        = swap;
  assign wr_err_o      = wr_err_q;
  assign state_o       = state_q;

endmodule
